addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 req0_valid  input  1  requester 0 has an operation pending.
REQ-004 req0_ready  output  1  requester 0 operation accepted on this edge; single-cycle pulse.
REQ-005 req0_a, req0_b  input  4 each  requester 0 operands.
REQ-006 req0_sub  input  1  requester 0 op: 1 = A-B, 0 = A+B.
REQ-007 req1_valid, req1_ready, req1_a, req1_b, req1_sub  same widths and meaning for requester 1.
REQ-008 rsp0_valid  output  1  requester 0 result held and valid.
REQ-009 rsp0_ready  input  1  requester 0 consumes its result.
REQ-010 rsp0_s  output  4  result; rsp0_c  output  1  carry-out; rsp0_v  output  1  signed overflow.
REQ-011 rsp1_valid, rsp1_ready, rsp1_s, rsp1_c, rsp1_v  same for requester 1.
REQ-012 dp_a, dp_b  output  4 each  operands to the shared 4-bit add/sub unit.
REQ-013 dp_m  output  1  mode to the shared unit: 1 = add, 0 = subtract.
REQ-014 dp_s  input  4, dp_c  input  1, dp_v  input  1  combinational result from the shared unit.
REQ-015 gnt  output  2  one-hot grant currently executing; 2'b00 when idle.

Function
REQ-016 FSM states: IDLE, EXEC; exactly one op in flight.
REQ-017 Port N is eligible in IDLE iff reqN_valid=1 and rspN_valid=0; rspN_ready in the same cycle does not make it eligible.
REQ-018 IDLE with at least one eligible port: pick winner, assert reqN_ready for that cycle only, latch a, b, sub and grant id at the edge, go to EXEC.
REQ-019 IDLE with no eligible port: stay IDLE; all reqN_ready = 0.
REQ-020 EXEC: dp_a/dp_b = latched operands, dp_m = ~latched sub, gnt = latched one-hot; at the edge ending EXEC, capture dp_s/dp_c/dp_v into the winner's rsp registers, set rspN_valid=1, return to IDLE.
REQ-021 IDLE: dp_a = dp_b = 0, dp_m = 1, gnt = 0.
REQ-022 Latency: accepted at edge k -> rspN_valid=1 after edge k+1; sustained throughput one op per 2 cycles.
REQ-023 rspN_valid clears at the edge where rspN_valid=1 and rspN_ready=1; s/c/v hold their values until overwritten.
REQ-024 rspN_s/c/v are stable while rspN_valid=1 and rspN_ready=0.
REQ-025 The other port's result register is never modified by an operation.
REQ-026 Carry is passed through unmodified: on subtract, C=1 means no borrow.
REQ-027 Deasserting reqN_valid before acceptance is legal; no op is recorded.

Reset
REQ-028 rst=1 at an edge forces IDLE, gnt=0, all reqN_ready=0, rspN_valid=0, rspN_s=0, rspN_c=0, rspN_v=0, round-robin pointer to "port 0 preferred".
REQ-029 Reset during EXEC discards the in-flight op; no rsp_valid is produced for it.

Configuration
REQ-030 Macro ADDSUB_ARB_FIXED_PRIO_EN defined: port 0 always wins when both are eligible.
REQ-031 Macro not defined: round-robin; when both are eligible, the port not granted most recently wins; after reset, port 0 wins first.

Verification
REQ-032 req0: a=5, b=3, sub=0 -> dp_m=1 in EXEC; rsp0_s=8, c=0, v=1, valid two edges after req0_valid rises.
REQ-033 req1: a=3, b=5, sub=1 -> dp_m=0; rsp1_s=4'hE, c=0, v=0; then a=7, b=2, sub=1 -> s=5, c=1, v=0.
REQ-034 Both valid continuously, rsp_ready=1, no macro -> grants alternate 0,1,0,1; with ADDSUB_ARB_FIXED_PRIO_EN, port 0 granted every op until rsp0 blocks.
REQ-035 rsp0_ready=0 with rsp0_valid=1, req0_valid=1 -> req0_ready stays 0, req1 still served; rsp0_s unchanged.
REQ-036 rst=1 during EXEC -> next cycle gnt=0, rsp0_valid=rsp1_valid=0; first post-reset op completes normally.

Source files
------------

// File: rtl/addsub_arbiter.sv
// Two-port arbiter sharing one external 4-bit add/sub unit, with one operation in flight.
// Define ADDSUB_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); the default is round-robin.
module addsub_arbiter #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_sub,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_sub,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_s,
    output logic              rsp0_c,
    output logic              rsp0_v,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_s,
    output logic              rsp1_c,
    output logic              rsp1_v,
    output logic [DATA_W-1:0] dp_a,
    output logic [DATA_W-1:0] dp_b,
    output logic              dp_m,
    input  logic [DATA_W-1:0] dp_s,
    input  logic              dp_c,
    input  logic              dp_v,
    output logic [1:0]        gnt
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t            state, state_nxt;
    logic              elig0, elig1, pick1, accept;
    logic [DATA_W-1:0] a_p0, b_p0;
    logic              sub_p0, id_p0;
    logic              last_gnt;

    // A port holding an unconsumed result may not start another operation.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        elig0      = req0_valid & ~rsp0_valid;
        elig1      = req1_valid & ~rsp1_valid;
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
        pick1      = elig1 & ~elig0;
`else
        pick1      = elig1 & (~elig0 | ~last_gnt);
`endif
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if ((elig0 | elig1) && !rst) begin
                    accept     = 1'b1;
                    req0_ready = ~pick1;
                    req1_ready = pick1;
                    state_nxt  = EXEC;
                end
            end
            EXEC: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept)
                last_gnt <= pick1;
        end
    end

    // Stage p0: operands of the accepted request, held for the EXEC cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0   <= pick1 ? req1_a   : req0_a;
            b_p0   <= pick1 ? req1_b   : req0_b;
            sub_p0 <= pick1 ? req1_sub : req0_sub;
            id_p0  <= pick1;
        end
    end

    assign dp_a = (state == EXEC) ? a_p0 : '0;
    assign dp_b = (state == EXEC) ? b_p0 : '0;
    assign dp_m = (state == EXEC) ? ~sub_p0 : 1'b1;
    assign gnt  = (state == EXEC) ? (id_p0 ? 2'b10 : 2'b01) : 2'b00;

    // Result stage: capture the shared unit output into the winner's slot only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_s     <= '0;
            rsp0_c     <= 1'b0;
            rsp0_v     <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_s     <= '0;
            rsp1_c     <= 1'b0;
            rsp1_v     <= 1'b0;
        end else begin
            if (state == EXEC && !id_p0) begin
                rsp0_valid <= 1'b1;
                rsp0_s     <= dp_s;
                rsp0_c     <= dp_c;
                rsp0_v     <= dp_v;
            end else if (rsp0_valid && rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end
            if (state == EXEC && id_p0) begin
                rsp1_valid <= 1'b1;
                rsp1_s     <= dp_s;
                rsp1_c     <= dp_c;
                rsp1_v     <= dp_v;
            end else if (rsp1_valid && rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter; models the external add/sub unit and checks each scenario inline.
module tb_addsub_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_sub, req1_valid, req1_ready, req1_sub;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp0_ready, rsp0_c, rsp0_v, rsp1_valid, rsp1_ready, rsp1_c, rsp1_v;
    logic [3:0] rsp0_s, rsp1_s, dp_a, dp_b, dp_s;
    logic       dp_m, dp_c, dp_v;
    logic [1:0] gnt;
    logic [4:0] sum;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    addsub_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_s(rsp0_s), .rsp0_c(rsp0_c), .rsp0_v(rsp0_v),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_s(rsp1_s), .rsp1_c(rsp1_c), .rsp1_v(rsp1_v),
        .dp_a(dp_a), .dp_b(dp_b), .dp_m(dp_m), .dp_s(dp_s), .dp_c(dp_c), .dp_v(dp_v),
        .gnt(gnt)
    );

    // Shared add/sub unit: dp_m=1 adds, dp_m=0 computes A + ~B + 1.
    always_comb begin
        sum  = dp_m ? ({1'b0, dp_a} + {1'b0, dp_b}) : ({1'b0, dp_a} + {1'b0, ~dp_b} + 5'd1);
        dp_s = sum[3:0];
        dp_c = sum[4];
        dp_v = dp_m ? ((dp_a[3] == dp_b[3]) && (sum[3] != dp_a[3]))
                    : ((dp_a[3] != dp_b[3]) && (sum[3] != dp_a[3]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt got %b want 00", gnt); end
        tests++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid got %b want 00", {rsp0_valid, rsp1_valid}); end
        tests++; if ({rsp0_s, rsp0_c, rsp0_v, rsp1_s, rsp1_c, rsp1_v} !== 12'h000) begin fails++; $display("FAIL reset_rsp_data got %h want 000", {rsp0_s, rsp0_c, rsp0_v, rsp1_s, rsp1_c, rsp1_v}); end
        tests++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b want 00", {req0_ready, req1_ready}); end
        tests++; if ({dp_a, dp_b, dp_m} !== 9'b0000_0000_1) begin fails++; $display("FAIL idle_dp got %b want 000000001", {dp_a, dp_b, dp_m}); end
    endtask

    task automatic test_add();
        req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd3; req0_sub = 1'b0;
        #1;
        tests++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL add_req_ready got %b want 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        tests++; if ({gnt, dp_a, dp_b, dp_m} !== {2'b01, 4'd5, 4'd3, 1'b1}) begin fails++; $display("FAIL add_exec got %b want 01010100111", {gnt, dp_a, dp_b, dp_m}); end
        tests++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL add_ready_pulse got %b want 0", req0_ready); end
        tick();
        tests++; if ({rsp0_valid, rsp0_s, rsp0_c, rsp0_v} !== {1'b1, 4'd8, 1'b0, 1'b1}) begin fails++; $display("FAIL add_rsp got %b want 1100001", {rsp0_valid, rsp0_s, rsp0_c, rsp0_v}); end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        tests++; if ({rsp0_valid, rsp0_s} !== {1'b0, 4'd8}) begin fails++; $display("FAIL add_consume got %b want 01000", {rsp0_valid, rsp0_s}); end
    endtask

    task automatic test_sub();
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd5; req1_sub = 1'b1;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b01) begin fails++; $display("FAIL sub_ready got %b want 01", {req0_ready, req1_ready}); end
        tick();
        req1_valid = 1'b0;
        #1;
        tests++; if ({gnt, dp_m} !== 3'b100) begin fails++; $display("FAIL sub_exec got %b want 100", {gnt, dp_m}); end
        tick();
        tests++; if ({rsp1_valid, rsp1_s, rsp1_c, rsp1_v} !== {1'b1, 4'hE, 1'b0, 1'b0}) begin fails++; $display("FAIL sub_rsp_neg got %b want 1111000", {rsp1_valid, rsp1_s, rsp1_c, rsp1_v}); end
        tests++; if ({rsp0_valid, rsp0_s, rsp0_c, rsp0_v} !== {1'b0, 4'd8, 1'b0, 1'b1}) begin fails++; $display("FAIL sub_other_port got %b want 0100001", {rsp0_valid, rsp0_s, rsp0_c, rsp0_v}); end
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd2; req1_sub = 1'b1;
        tick();
        req1_valid = 1'b0;
        tick();
        tests++; if ({rsp1_valid, rsp1_s, rsp1_c, rsp1_v} !== {1'b1, 4'd5, 1'b1, 1'b0}) begin fails++; $display("FAIL sub_rsp_pos got %b want 1010110", {rsp1_valid, rsp1_s, rsp1_c, rsp1_v}); end
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_gnt [4];
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd6; req1_sub = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (gnt !== exp_gnt[i]) begin fails++; $display("FAIL b2b_gnt%0d got %b want %b", i, gnt, exp_gnt[i]); end
            tick();
            if (i == 0) begin
                tests++; if ({rsp0_valid, rsp0_s, rsp0_c} !== {1'b1, 4'd2, 1'b0}) begin fails++; $display("FAIL b2b_rsp0 got %b want 100100", {rsp0_valid, rsp0_s, rsp0_c}); end
            end
            if (i == 1) begin
                tests++; if ({rsp1_valid, rsp1_s, rsp1_c} !== {1'b1, 4'hE, 1'b0}) begin fails++; $display("FAIL b2b_rsp1 got %b want 111100", {rsp1_valid, rsp1_s, rsp1_c}); end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_priority();
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd2; req0_sub = 1'b0;
        tick();
        req0_valid = 1'b0;
        tick();
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
        tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL prio_ready got %b want 10", {req0_ready, req1_ready}); end
`else
        tests++; if ({req0_ready, req1_ready} !== 2'b01) begin fails++; $display("FAIL rr_ready got %b want 01", {req0_ready, req1_ready}); end
`endif
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tests++; if ({rsp0_valid, rsp1_valid, gnt} !== 4'b0000) begin fails++; $display("FAIL prio_drain got %b want 0000", {rsp0_valid, rsp1_valid, gnt}); end
    endtask

    task automatic test_blocked();
        req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd1; req0_sub = 1'b0;
        tick();
        tick();
        req0_a = 4'd1; req0_b = 4'd1;
        req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd3; req1_sub = 1'b1;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b01) begin fails++; $display("FAIL blk_ready got %b want 01", {req0_ready, req1_ready}); end
        tick();
        req1_valid = 1'b0;
        tests++; if (gnt !== 2'b10) begin fails++; $display("FAIL blk_gnt got %b want 10", gnt); end
        tick();
        tests++; if ({rsp1_valid, rsp1_s, rsp1_c, rsp1_v} !== {1'b1, 4'hF, 1'b0, 1'b0}) begin fails++; $display("FAIL blk_rsp1 got %b want 1111100", {rsp1_valid, rsp1_s, rsp1_c, rsp1_v}); end
        tests++; if ({rsp0_valid, rsp0_s} !== {1'b1, 4'd7}) begin fails++; $display("FAIL blk_rsp0_hold got %b want 10111", {rsp0_valid, rsp0_s}); end
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        tests++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL blk_same_cycle got %b want 0", req0_ready); end
        tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tests++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL blk_release got %b want 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        tick();
        tests++; if ({rsp0_valid, rsp0_s, rsp0_c} !== {1'b1, 4'd2, 1'b0}) begin fails++; $display("FAIL blk_rsp0_new got %b want 100100", {rsp0_valid, rsp0_s, rsp0_c}); end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
    endtask

    task automatic test_reset_exec();
        req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd4; req0_sub = 1'b0;
        tick();
        req0_valid = 1'b0;
        tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL rstx_pre_gnt got %b want 01", gnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if ({gnt, rsp0_valid, rsp1_valid, rsp0_s} !== 8'b0) begin fails++; $display("FAIL rstx_state got %b want 00000000", {gnt, rsp0_valid, rsp1_valid, rsp0_s}); end
        tick();
        tests++; if (rsp0_valid !== 1'b0) begin fails++; $display("FAIL rstx_discard got %b want 0", rsp0_valid); end
        req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd9; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; req1_sub = 1'b0;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL rstx_first_win got %b want 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tests++; if ({rsp0_valid, rsp0_s, rsp0_c, rsp0_v} !== {1'b1, 4'd2, 1'b1, 1'b1}) begin fails++; $display("FAIL rstx_post_op got %b want 1001011", {rsp0_valid, rsp0_s, rsp0_c, rsp0_v}); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_priority();
        test_blocked();
        test_reset_exec();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
